rvfpm_issue_scheduler: RTL
==========================

// Module: rvfpm_issue_scheduler
// PURPOSE
//  Issue scheduler between the CORE-V-XIF offload port and the rvfpm execute pipeline.
//  Buffers offloaded FP instructions in an in-order queue and dispatches the head when
//  no register hazard exists. Tracks in-flight ids in a shadow pipeline to free the
//  scoreboard at writeback. Handles commit-kill and a full flush/drain.
// PARAMETERS
//  X_ID_WIDTH      4   width of XIF instruction id
//  NUM_REGS        32  FP register count; RW = $clog2(NUM_REGS)
//  PIPELINE_STAGES 4   fixed execute latency in advancing cycles (>=1)
//  QUEUE_DEPTH     4   issue queue entries (>=2)
// PORTS
//  ck            in   1      clock
//  rst           in   1      synchronous reset, active-high
//  enable        in   1      0: no accept, no dispatch, shadow pipe frozen
//  flush         in   1      request drain (sampled in RUN only)
//  issue_valid   in   1      offload request
//  issue_ready   out  1      queue can accept
//  issue_id      in   X      instruction id
//  issue_rd      in   RW     destination register
//  issue_rs1/2/3 in   RW     source registers
//  issue_rs_used in   3      bit i: rs(i+1) is read
//  issue_we      in   1      instruction writes rd
//  commit_valid  in   1      commit strobe
//  commit_id     in   X      id being committed
//  commit_kill   in   1      kill commit_id
//  pipe_stall    in   1      execute pipeline holds this cycle
//  disp_valid    out  1      head dispatched this cycle
//  disp_id       out  X      dispatched id
//  wb_valid      out  1      instruction retires from last stage
//  wb_id / wb_rd out  X/RW   retiring id / register
//  busy          out  1      queue or shadow pipe non-empty
//  flush_done    out  1      one-cycle pulse at drain end
//  queue_ids     out  QUEUE_DEPTH*X      slot 0 = head; empty slots 0
//  pipeline_ids  out  PIPELINE_STAGES*X  slot 0 = newest; empty slots 0
// BEHAVIOUR
//  - Reset: queue empty, scoreboard clear, shadow pipe empty, FSM=RUN; all outputs 0.
//  - accept = issue_valid & issue_ready; issue_ready = enable & RUN & ~rst & count<QUEUE_DEPTH.
//    Same-cycle dispatch does not raise ready; a full queue stays unready.
//  - No bypass: an entry accepted at edge t can dispatch in cycle t+1 at the earliest.
//  - Hazard, using the registered scoreboard: sb[rsN] for each used source, or
//    issue_we & sb[rd] (WAW).
//  - disp_valid (combinational) = RUN & enable & ~pipe_stall & head live & ~hazard.
//  - On dispatch: pop; entry enters shadow stage 0; sb[rd] is set at the edge if we.
//  - Shadow pipe advances when enable & ~pipe_stall. On the last stage:
//    wb_valid = valid & ~killed & advance. sb[rd] is cleared at that edge, killed or not.
//  - Dispatch cycle d, no stalls: wb in cycle d+PIPELINE_STAGES.
//    A dependent instruction dispatches no earlier than d+PIPELINE_STAGES+1.
//  - Kill (commit_valid & commit_kill): every queue/shadow entry with id==commit_id is
//    marked killed. A killed head pops without disp_valid, one per cycle, ignoring
//    hazard and stall. A kill applies to an entry accepted in the same cycle.
//  - Commit without kill: no effect on scheduling.
//  - Simultaneous accept and pop: count unchanged. The pointer wraps modulo QUEUE_DEPTH.
//  - FSM: RUN --flush--> DRAIN. In DRAIN: queue cleared at entry; no accept or
//    dispatch; shadow pipe drains.
//    DRAIN --shadow empty--> DONE: flush_done=1 for one cycle --> RUN.
//  - rst mid-operation overrides everything; in-flight state is discarded.
// TESTING
//  1 Reset, then issue id=1 rd=3 rs=none -> disp_valid next cycle;
//    wb_valid,wb_id=1,wb_rd=3 exactly 4 cycles after dispatch.
//  2 RAW: id1 writes f5; id2 reads rs1=f5 -> id2 dispatches the cycle after id1 wb
//    (d+5). WAW on f5 behaves the same.
//  3 Fill: 5 back-to-back issues with a hazard at head -> issue_ready=0 after 4;
//    queue_ids={1,2,3,4}; wrap verified over 10 issues.
//  4 Kill id=2 while queued behind id=1 -> id2 popped without disp_valid; id3 dispatches;
//    killing an in-flight id -> no wb_valid, scoreboard freed.
//  5 pipe_stall=1 for 3 cycles mid-flight -> wb delayed by 3; pipeline_ids frozen.
//  6 flush with 2 queued + 2 in flight -> queue empty next cycle; flush_done once after
//    the last wb; then issue_ready=1. rst asserted mid-drain -> clean RUN state.

Source files
------------

// File: rtl/rvfpm_issue_scheduler.sv
// Issue scheduler between the CORE-V-XIF offload port and the rvfpm execute pipeline:
// in-order issue queue, register scoreboard, shadow pipeline of in-flight ids, kill and drain.
module rvfpm_issue_scheduler #(
    parameter int  X_ID_WIDTH      = 4,
    parameter int  NUM_REGS        = 32,
    parameter int  PIPELINE_STAGES = 4,
    parameter int  QUEUE_DEPTH     = 4,
    localparam int RW              = $clog2(NUM_REGS)
) (
    input  logic                                  i_ck,
    input  logic                                  i_rst,
    input  logic                                  i_enable,
    input  logic                                  i_flush,
    input  logic                                  i_issue_valid,
    output logic                                  o_issue_ready,
    input  logic [X_ID_WIDTH-1:0]                 i_issue_id,
    input  logic [RW-1:0]                         i_issue_rd,
    input  logic [RW-1:0]                         i_issue_rs1,
    input  logic [RW-1:0]                         i_issue_rs2,
    input  logic [RW-1:0]                         i_issue_rs3,
    input  logic [2:0]                            i_issue_rs_used,
    input  logic                                  i_issue_we,
    input  logic                                  i_commit_valid,
    input  logic [X_ID_WIDTH-1:0]                 i_commit_id,
    input  logic                                  i_commit_kill,
    input  logic                                  i_pipe_stall,
    output logic                                  o_disp_valid,
    output logic [X_ID_WIDTH-1:0]                 o_disp_id,
    output logic                                  o_wb_valid,
    output logic [X_ID_WIDTH-1:0]                 o_wb_id,
    output logic [RW-1:0]                         o_wb_rd,
    output logic                                  o_busy,
    output logic                                  o_flush_done,
    output logic [QUEUE_DEPTH*X_ID_WIDTH-1:0]     o_queue_ids,
    output logic [PIPELINE_STAGES*X_ID_WIDTH-1:0] o_pipeline_ids
);

    localparam int PW   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW   = $clog2(QUEUE_DEPTH + 1);
    localparam int LAST = PIPELINE_STAGES - 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [RW-1:0]         rd;
        logic [RW-1:0]         rs1;
        logic [RW-1:0]         rs2;
        logic [RW-1:0]         rs3;
        logic [2:0]            rs_used;
        logic                  we;
        logic                  killed;
    } q_entry_t;

    typedef struct packed {
        logic                  valid;
        logic                  killed;
        logic [X_ID_WIDTH-1:0] id;
        logic [RW-1:0]         rd;
        logic                  we;
    } s_entry_t;

    state_e               r_state;
    state_e               w_state_nxt;
    q_entry_t             r_queue [QUEUE_DEPTH];
    s_entry_t             r_shadow [PIPELINE_STAGES];
    s_entry_t             w_shadow_mk [PIPELINE_STAGES];
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_wr_ptr;
    logic [CW-1:0]        r_count;
    logic [NUM_REGS-1:0]  r_sb;

    q_entry_t             w_head;
    q_entry_t             w_new;
    s_entry_t             w_disp_entry;
    logic                 w_run;
    logic                 w_kill;
    logic                 w_q_nonempty;
    logic                 w_head_live;
    logic                 w_kill_pop;
    logic                 w_hazard;
    logic                 w_pop;
    logic                 w_accept;
    logic                 w_advance;
    logic                 w_retire;
    logic                 w_shadow_any;
    logic                 w_flush_start;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_run         = (r_state == S_RUN);
    assign w_kill        = i_commit_valid & i_commit_kill;
    assign w_head        = r_queue[r_rd_ptr];
    assign w_q_nonempty  = (r_count != '0);
    assign w_head_live   = w_q_nonempty & ~w_head.killed;
    assign w_flush_start = w_run & i_flush;

    // Sources and WAW are checked against the registered scoreboard only; no bypass.
    always_comb begin
        w_hazard = w_head.we & r_sb[w_head.rd];
        if (w_head.rs_used[0] & r_sb[w_head.rs1]) w_hazard = 1'b1;
        if (w_head.rs_used[1] & r_sb[w_head.rs2]) w_hazard = 1'b1;
        if (w_head.rs_used[2] & r_sb[w_head.rs3]) w_hazard = 1'b1;
    end

    assign o_issue_ready = i_enable & w_run & ~i_rst & (r_count < CW'(QUEUE_DEPTH));
    assign w_accept      = i_issue_valid & o_issue_ready;
    assign o_disp_valid  = w_run & i_enable & ~i_pipe_stall & w_head_live & ~w_hazard & ~i_rst;
    assign o_disp_id     = o_disp_valid ? w_head.id : '0;
    // A killed head is discarded regardless of hazards or a stalled execute pipe.
    assign w_kill_pop    = w_run & i_enable & w_q_nonempty & w_head.killed & ~i_rst;
    assign w_pop         = o_disp_valid | w_kill_pop;
    assign w_advance     = i_enable & ~i_pipe_stall;
    assign w_retire      = w_advance & r_shadow[LAST].valid;
    assign o_wb_valid    = w_retire & ~r_shadow[LAST].killed & ~i_rst;
    assign o_wb_id       = o_wb_valid ? r_shadow[LAST].id : '0;
    assign o_wb_rd       = o_wb_valid ? r_shadow[LAST].rd : '0;
    assign o_busy        = w_q_nonempty | w_shadow_any;

    always_comb begin
        w_new         = '0;
        w_new.id      = i_issue_id;
        w_new.rd      = i_issue_rd;
        w_new.rs1     = i_issue_rs1;
        w_new.rs2     = i_issue_rs2;
        w_new.rs3     = i_issue_rs3;
        w_new.rs_used = i_issue_rs_used;
        w_new.we      = i_issue_we;
        w_new.killed  = w_kill & (i_issue_id == i_commit_id);
    end

    always_comb begin
        w_disp_entry = '0;
        if (o_disp_valid) begin
            w_disp_entry.valid  = 1'b1;
            w_disp_entry.killed = w_kill & (w_head.id == i_commit_id);
            w_disp_entry.id     = w_head.id;
            w_disp_entry.rd     = w_head.rd;
            w_disp_entry.we     = w_head.we;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_shadow_any = 1'b0;
        for (int i = 0; i < PIPELINE_STAGES; i++) begin
            w_shadow_mk[i] = r_shadow[i];
            if (w_kill && r_shadow[i].valid && (r_shadow[i].id == i_commit_id))
                w_shadow_mk[i].killed = 1'b1;
            w_shadow_any = w_shadow_any | r_shadow[i].valid;
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush_start) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)    r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: queue payload is not reset; r_count alone decides which slots hold live data.
    always_ff @(posedge i_ck) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (w_kill && (r_queue[i].id == i_commit_id)) r_queue[i].killed <= 1'b1;
        end
        if (w_accept) r_queue[r_wr_ptr] <= w_new;
    end

    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            for (int i = 0; i < PIPELINE_STAGES; i++) r_shadow[i] <= '0;
        end else if (w_advance) begin
            r_shadow[0] <= w_disp_entry;
            for (int i = 1; i < PIPELINE_STAGES; i++) r_shadow[i] <= w_shadow_mk[i-1];
        end else begin
            for (int i = 0; i < PIPELINE_STAGES; i++) r_shadow[i] <= w_shadow_mk[i];
        end
    end

    // The retiring register is released even when its instruction was killed.
    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            r_sb <= '0;
        end else begin
            if (w_retire && r_shadow[LAST].we) r_sb[r_shadow[LAST].rd] <= 1'b0;
            if (o_disp_valid && w_head.we)     r_sb[w_head.rd]         <= 1'b1;
        end
    end

    always_ff @(posedge i_ck) begin
        if (i_rst) r_state <= S_RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_flush_done = 1'b0;
        case (r_state)
            S_RUN:   if (i_flush) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!w_shadow_any) w_state_nxt = S_DONE;
            S_DONE: begin
                o_flush_done = ~i_rst;
                w_state_nxt  = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        o_queue_ids = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (CW'(i) < r_count)
                o_queue_ids[i*X_ID_WIDTH +: X_ID_WIDTH] =
                    r_queue[PW'((int'(r_rd_ptr) + i) % QUEUE_DEPTH)].id;
        end
    end

    always_comb begin
        o_pipeline_ids = '0;
        for (int i = 0; i < PIPELINE_STAGES; i++) begin
            if (r_shadow[i].valid) o_pipeline_ids[i*X_ID_WIDTH +: X_ID_WIDTH] = r_shadow[i].id;
        end
    end

endmodule
